// File: rtl/rep_wb_pkg.sv
// Shared types for the writeback REP/REPE/REPNE sequencer and its term detector.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: FSM state encoding, repeat-mode codes, registered pulse bundle, default ZF position.
package rep_wb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ITER = 2'b01,
    ST_DONE = 2'b10
  } rep_state_t;

  typedef enum logic [1:0] {
    MODE_NONE  = 2'b00,
    MODE_REP   = 2'b01,
    MODE_REPE  = 2'b10,
    MODE_REPNE = 2'b11
  } rep_mode_t;

  // One-cycle front-end / count-writeback pulses, registered as a group.
  typedef struct packed {
    logic ld_count;
    logic restart;
    logic terminate;
    logic skip;
  } rep_pulse_t;

  localparam int ZF_BIT_DEF = 6;

endpackage

// File: rtl/rep_term_detect.sv
// Decides whether a repeated string instruction stops after the current iteration.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
// Ports: cnt_next (count after decrement), mode (latched repeat mode), zf (flag after uop), term (stop).
module rep_term_detect
  import rep_wb_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic [CNT_W-1:0] cnt_next,
  input  logic [1:0]       mode,
  input  logic             zf,
  output logic             term
);

  always_comb begin
    term = (cnt_next == '0)
         | ((mode == MODE_REPE)  & ~zf)
         | ((mode == MODE_REPNE) &  zf);
  end

endmodule

// File: rtl/rep_sequencer_wb.sv
// Writeback sequencer for REP/REPE/REPNE: holds the iteration count and issues redirect pulses.
// Latency: every pulse output is registered, one cycle after its qualifying WB event, one cycle wide.
// Backpressure: WB_STALL freezes ITER/IDLE state and count; WB_FLUSH aborts to IDLE keeping the count.
// Ports: CLK/CLR (sync active-high), WB_V/WB_STALL/WB_FLUSH, rep_mode/rep_start/iter_done/count_in/current_flags in;
//        rep_active, count_out, ld_count, rep_restart, rep_terminate, rep_skip out.
module rep_sequencer_wb
  import rep_wb_pkg::*;
#(
  parameter int CNT_W  = 32,
  parameter int ZF_BIT = ZF_BIT_DEF,
  parameter int FLAG_W = 32
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              WB_V,
  input  logic              WB_STALL,
  input  logic              WB_FLUSH,
  input  logic [1:0]        rep_mode,
  input  logic              rep_start,
  input  logic              iter_done,
  input  logic [CNT_W-1:0]  count_in,
  input  logic [FLAG_W-1:0] current_flags,
  output logic              rep_active,
  output logic [CNT_W-1:0]  count_out,
  output logic              ld_count,
  output logic              rep_restart,
  output logic              rep_terminate,
  output logic              rep_skip
);

  rep_state_t       state_q, state_d;
  rep_mode_t        mode_q, mode_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_dec;
  rep_pulse_t       pulse_q, pulse_d;
  logic             ev_start, ev_iter, zf, term;
  logic             unused_flags;

  assign zf           = current_flags[ZF_BIT];
  assign unused_flags = ^current_flags;

  assign ev_start = WB_V & rep_start & ~WB_STALL & (rep_mode != MODE_NONE);
  assign ev_iter  = WB_V & iter_done & ~WB_STALL & (state_q == ST_ITER);

  // cnt_q is never zero while in ITER, so the decrement cannot wrap.
  assign cnt_dec = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};

  rep_term_detect #(.CNT_W(CNT_W)) u_term (
    .cnt_next (cnt_dec),
    .mode     (mode_q),
    .zf       (zf),
    .term     (term)
  );

  // State register.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      mode_q  <= MODE_NONE;
      pulse_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      pulse_q <= pulse_d;
    end
  end

  // Next-state logic. Pulses default to zero so each lasts exactly one cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    pulse_d = '0;
    if (WB_FLUSH) begin
      // Abort without touching the count: nothing architectural was written.
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ev_start) begin
            if (count_in == '0) begin
              pulse_d.skip      = 1'b1;
              pulse_d.terminate = 1'b1;
            end else begin
              cnt_d   = count_in;
              mode_d  = rep_mode_t'(rep_mode);
              state_d = ST_ITER;
            end
          end
        end
        ST_ITER: begin
          // A rep_start here is a protocol error and is deliberately ignored.
          if (ev_iter) begin
            cnt_d            = cnt_dec;
            pulse_d.ld_count = 1'b1;
            if (term) begin
              pulse_d.terminate = 1'b1;
              state_d           = ST_DONE;
            end else begin
              pulse_d.restart = 1'b1;
            end
          end
        end
        // DONE only stretches rep_active across the terminate pulse.
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Outputs.
  always_comb begin
    rep_active    = (state_q == ST_ITER) | (state_q == ST_DONE);
    count_out     = cnt_q;
    ld_count      = pulse_q.ld_count;
    rep_restart   = pulse_q.restart;
    rep_terminate = pulse_q.terminate;
    rep_skip      = pulse_q.skip;
  end

endmodule

// File: tb/tb_rep_sequencer_wb.sv
// Bench for rep_sequencer_wb: directed vector table, then random traffic against a behavioural model.
// Latency: n/a.
// Backpressure: n/a.
module tb_rep_sequencer_wb;

  logic        clk;
  logic        clr, wb_v, wb_stall, wb_flush, rep_start, iter_done;
  logic [1:0]  rep_mode;
  logic [31:0] count_in, flags;

  logic        act32, ld32, rs32, tm32, sk32;
  logic [31:0] cnt32;
  logic        act16, ld16, rs16, tm16, sk16;
  logic [15:0] cnt16;

  int vectors = 0;
  int miscompares = 0;

  rep_sequencer_wb #(.CNT_W(32), .ZF_BIT(6), .FLAG_W(32)) dut32 (
    .CLK(clk), .CLR(clr), .WB_V(wb_v), .WB_STALL(wb_stall), .WB_FLUSH(wb_flush),
    .rep_mode(rep_mode), .rep_start(rep_start), .iter_done(iter_done),
    .count_in(count_in), .current_flags(flags),
    .rep_active(act32), .count_out(cnt32), .ld_count(ld32),
    .rep_restart(rs32), .rep_terminate(tm32), .rep_skip(sk32)
  );

  rep_sequencer_wb #(.CNT_W(16), .ZF_BIT(6), .FLAG_W(32)) dut16 (
    .CLK(clk), .CLR(clr), .WB_V(wb_v), .WB_STALL(wb_stall), .WB_FLUSH(wb_flush),
    .rep_mode(rep_mode), .rep_start(rep_start), .iter_done(iter_done),
    .count_in(count_in[15:0]), .current_flags(flags),
    .rep_active(act16), .count_out(cnt16), .ld_count(ld16),
    .rep_restart(rs16), .rep_terminate(tm16), .rep_skip(sk16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit        clr, v, stall, flush;
    bit [1:0]  mode;
    bit        start, iter, zf;
    bit [31:0] cin;
    bit        e_act, e_ld, e_rs, e_tm, e_sk;
    bit [31:0] e_cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit c, input bit v, input bit s, input bit f, input bit [1:0] m,
                     input bit st, input bit it, input bit z, input bit [31:0] ci,
                     input bit ea, input bit el, input bit er, input bit et, input bit es,
                     input bit [31:0] ec);
    vec_t t;
    t.clr = c; t.v = v; t.stall = s; t.flush = f; t.mode = m;
    t.start = st; t.iter = it; t.zf = z; t.cin = ci;
    t.e_act = ea; t.e_ld = el; t.e_rs = er; t.e_tm = et; t.e_sk = es; t.e_cnt = ec;
    tbl.push_back(t);
  endtask

  task automatic drive(input bit c, input bit v, input bit s, input bit f, input bit [1:0] m,
                       input bit st, input bit it, input bit [31:0] fl, input bit [31:0] ci);
    clr = c; wb_v = v; wb_stall = s; wb_flush = f; rep_mode = m;
    rep_start = st; iter_done = it; flags = fl; count_in = ci;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int idx, input logic [36:0] got, input logic [36:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s #%0d: got act/ld/rs/tm/sk/cnt=%b %b %b %b %b %h, expected %b %b %b %b %b %h",
               name, idx, got[36], got[35], got[34], got[33], got[32], got[31:0],
               exp[36], exp[35], exp[34], exp[33], exp[32], exp[31:0]);
    end
  endtask

  // Behavioural model: "in_seq" = iterations outstanding, "tail" = the cycle after a terminate
  // where the instruction is still reported active.
  bit        m_in_seq[2], m_tail[2];
  bit [1:0]  m_mode[2];
  bit [31:0] m_cnt[2];
  bit        m_ld[2], m_rs[2], m_tm[2], m_sk[2];

  task automatic model_step(input int i, input bit [31:0] mask, input bit c, input bit v, input bit s,
                            input bit f, input bit [1:0] m, input bit st, input bit it, input bit z,
                            input bit [31:0] ci);
    bit [31:0] left;
    m_ld[i] = 0; m_rs[i] = 0; m_tm[i] = 0; m_sk[i] = 0;
    if (c) begin
      m_in_seq[i] = 0; m_tail[i] = 0; m_cnt[i] = 0; m_mode[i] = 0;
    end else if (f) begin
      m_in_seq[i] = 0; m_tail[i] = 0;
    end else if (m_tail[i]) begin
      m_tail[i] = 0;
    end else if (m_in_seq[i]) begin
      if (v && it && !s) begin
        left = (m_cnt[i] - 1) & mask;
        m_cnt[i] = left;
        m_ld[i] = 1;
        if (left == 0 || (m_mode[i] == 2 && !z) || (m_mode[i] == 3 && z)) begin
          m_tm[i] = 1; m_in_seq[i] = 0; m_tail[i] = 1;
        end else begin
          m_rs[i] = 1;
        end
      end
    end else if (v && st && !s && m != 0) begin
      if ((ci & mask) == 0) begin
        m_sk[i] = 1; m_tm[i] = 1;
      end else begin
        m_cnt[i] = ci & mask; m_mode[i] = m; m_in_seq[i] = 1;
      end
    end
  endtask

  initial begin
    bit c, v, s, f, st, it, z;
    bit [1:0] m;
    bit [31:0] ci, fl;
    int r;

    clr = 1; wb_v = 0; wb_stall = 0; wb_flush = 0; rep_mode = 0;
    rep_start = 0; iter_done = 0; flags = 0; count_in = 0;

    // Reset
    add(1,0,0,0,0,0,0,0,0,          0,0,0,0,0,0);
    // REP, count 3: restart, restart, terminate
    add(0,1,0,0,1,1,0,0,3,          1,0,0,0,0,3);
    add(0,1,0,0,1,0,1,0,0,          1,1,1,0,0,2);
    add(0,1,0,0,1,0,1,0,0,          1,1,1,0,0,1);
    add(0,1,0,0,1,0,1,0,0,          1,1,0,1,0,0);
    add(0,0,0,0,0,0,0,0,0,          0,0,0,0,0,0);
    // REPNE, count 10, ZF=1 on second iteration
    add(0,1,0,0,3,1,0,0,10,         1,0,0,0,0,10);
    add(0,1,0,0,3,0,1,0,0,          1,1,1,0,0,9);
    add(0,1,0,0,3,0,1,1,0,          1,1,0,1,0,8);
    add(0,0,0,0,0,0,0,0,0,          0,0,0,0,0,8);
    // REPE, count 5, ZF=0 on first iteration
    add(0,1,0,0,2,1,0,1,5,          1,0,0,0,0,5);
    add(0,1,0,0,2,0,1,0,0,          1,1,0,1,0,4);
    add(0,0,0,0,0,0,0,0,0,          0,0,0,0,0,4);
    // Zero count: skip + terminate, count_out holds
    add(0,1,0,0,1,1,0,0,0,          0,0,0,1,1,4);
    add(0,0,0,0,0,0,0,0,0,          0,0,0,0,0,4);
    // Stall three cycles with iter_done high, then release
    add(0,1,0,0,1,1,0,0,8,          1,0,0,0,0,8);
    add(0,1,1,0,1,0,1,0,0,          1,0,0,0,0,8);
    add(0,1,1,0,1,0,1,0,0,          1,0,0,0,0,8);
    add(0,1,1,0,1,0,1,0,0,          1,0,0,0,0,8);
    add(0,1,0,0,1,0,1,0,0,          1,1,1,0,0,7);
    // Flush in ITER with cnt=7 beats a concurrent iter_done
    add(0,1,0,1,1,0,1,0,0,          0,0,0,0,0,7);
    add(0,0,0,0,0,0,0,0,0,          0,0,0,0,0,7);
    // 16'hFFFF, then reset mid-run
    add(0,1,0,0,1,1,0,0,32'hFFFF,   1,0,0,0,0,32'hFFFF);
    add(0,1,0,0,1,0,1,0,0,          1,1,1,0,0,32'hFFFE);
    add(1,1,0,0,1,0,1,0,0,          0,0,0,0,0,0);
    add(0,0,0,0,0,0,0,0,0,          0,0,0,0,0,0);
    // start+iter in IDLE: start wins; start in ITER ignored; latched mode used
    add(0,1,0,0,3,1,1,0,2,          1,0,0,0,0,2);
    add(0,1,0,0,1,1,0,0,9,          1,0,0,0,0,2);
    add(0,1,0,0,2,0,1,0,0,          1,1,1,0,0,1);
    add(0,1,0,0,0,0,1,0,0,          1,1,0,1,0,0);
    // start during DONE, mode 00, stalled start, unqualified events: all ignored
    add(0,1,0,0,1,1,0,0,5,          0,0,0,0,0,0);
    add(0,1,0,0,0,1,0,0,5,          0,0,0,0,0,0);
    add(0,1,1,0,1,1,0,0,5,          0,0,0,0,0,0);
    add(0,1,0,0,1,0,1,0,0,          0,0,0,0,0,0);
    add(0,0,0,0,1,1,0,0,5,          0,0,0,0,0,0);

    foreach (tbl[k]) begin
      drive(tbl[k].clr, tbl[k].v, tbl[k].stall, tbl[k].flush, tbl[k].mode,
            tbl[k].start, tbl[k].iter, tbl[k].zf ? 32'h40 : 32'h0, tbl[k].cin);
      check("table32", k, {act32, ld32, rs32, tm32, sk32, cnt32},
            {tbl[k].e_act, tbl[k].e_ld, tbl[k].e_rs, tbl[k].e_tm, tbl[k].e_sk, tbl[k].e_cnt});
      check("table16", k, {act16, ld16, rs16, tm16, sk16, 16'h0, cnt16},
            {tbl[k].e_act, tbl[k].e_ld, tbl[k].e_rs, tbl[k].e_tm, tbl[k].e_sk, 16'h0, tbl[k].e_cnt[15:0]});
    end

    // Randomized traffic; first cycle is a reset so the model starts in step.
    for (int n = 0; n < 3000; n++) begin
      c  = (n == 0) || ($urandom_range(0, 99) == 0);
      f  = ($urandom_range(0, 31) == 0);
      s  = ($urandom_range(0, 3) == 0);
      v  = ($urandom_range(0, 3) != 0);
      st = ($urandom_range(0, 3) == 0);
      it = ($urandom_range(0, 1) == 0);
      m  = 2'($urandom_range(0, 3));
      z  = 1'($urandom_range(0, 1));
      r  = $urandom_range(0, 7);
      case (r)
        0: ci = 0;
        5: ci = 32'h0001_0000;
        6: ci = 32'h0001_0002;
        7: ci = $urandom;
        default: ci = 32'(r);
      endcase
      fl = ($urandom & ~32'h40) | (z ? 32'h40 : 32'h0);
      drive(c, v, s, f, m, st, it, fl, ci);
      model_step(0, 32'hFFFF_FFFF, c, v, s, f, m, st, it, z, ci);
      model_step(1, 32'h0000_FFFF, c, v, s, f, m, st, it, z, ci);
      check("rand32", n, {act32, ld32, rs32, tm32, sk32, cnt32},
            {m_in_seq[0] | m_tail[0], m_ld[0], m_rs[0], m_tm[0], m_sk[0], m_cnt[0]});
      check("rand16", n, {act16, ld16, rs16, tm16, sk16, 16'h0, cnt16},
            {m_in_seq[1] | m_tail[1], m_ld[1], m_rs[1], m_tm[1], m_sk[1], m_cnt[1]});
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
